// File: rtl/cmd_mem_loader_if.sv
// -----------------------------------------------------------------------------
// cmd_mem_loader_if
//   Bundles the host word stream and the command memory write port seen by
//   cmd_mem_loader.
//
//   Host word stream:
//     word_in          host data word
//     word_valid       word_in valid
//     word_last        marks the final word of a program
//     word_ready       loader accepts a word this cycle
//   Command memory write port:
//     cmd_write_addr   command memory write address
//     cmd_write        packed command
//     cmd_write_enable one-cycle write strobe
//
//   Modports:
//     master  host / processor side (drives words, observes the write port)
//     slave   the loader itself
//   Parameters must match the ones given to cmd_mem_loader.
// -----------------------------------------------------------------------------
interface cmd_mem_loader_if #(
  parameter int CMD_WIDTH      = 128,
  parameter int CMD_ADDR_WIDTH = 8,
  parameter int WORD_WIDTH     = 32
);
  logic [WORD_WIDTH-1:0]     word_in;
  logic                      word_valid;
  logic                      word_last;
  logic                      word_ready;
  logic [CMD_ADDR_WIDTH-1:0] cmd_write_addr;
  logic [CMD_WIDTH-1:0]      cmd_write;
  logic                      cmd_write_enable;

  modport master (
    output word_in, word_valid, word_last,
    input  word_ready, cmd_write_addr, cmd_write, cmd_write_enable
  );

  modport slave (
    input  word_in, word_valid, word_last,
    output word_ready, cmd_write_addr, cmd_write, cmd_write_enable
  );
endinterface

// File: rtl/cmd_mem_loader.sv
// -----------------------------------------------------------------------------
// cmd_mem_loader
//   Loads a program into the processor's command memory and controls the
//   processor reset. 32-bit host words are packed (word k into bits
//   [WORD_WIDTH*(k+1)-1 : WORD_WIDTH*k]) into CMD_WIDTH-bit commands that are
//   written to consecutive addresses starting at 0. The core is held in reset
//   while loading and released on a start pulse.
//
//   Ports:
//     clk         system clock, rising edge
//     reset       synchronous active-high reset
//     bus         cmd_mem_loader_if.slave (word stream + command write port)
//     start       pulse: release the processor (IDLE or LOADED)
//     stop        pulse: abort, back to IDLE (wins over start)
//     proc_reset  processor reset, active-high (low only in RUN)
//     running     high in RUN
//     cmd_count   commands written by the last load, saturates at depth
//     overflow    sticky: program exceeded the command memory depth
//     checksum    XOR of the words of the current load
//                 (only when CMD_MEM_LOADER_CHECKSUM_EN is defined)
//
//   Optional feature macro: CMD_MEM_LOADER_CHECKSUM_EN
// -----------------------------------------------------------------------------
module cmd_mem_loader #(
  parameter int CMD_WIDTH      = 128,
  parameter int CMD_ADDR_WIDTH = 8,
  parameter int WORD_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  cmd_mem_loader_if.slave           bus,
  input  logic                      start,
  input  logic                      stop,
  output logic                      proc_reset,
  output logic                      running,
  output logic [CMD_ADDR_WIDTH:0]   cmd_count,
  output logic                      overflow
`ifdef CMD_MEM_LOADER_CHECKSUM_EN
  ,
  output logic [WORD_WIDTH-1:0]     checksum
`endif
);

  localparam int W      = CMD_WIDTH / WORD_WIDTH;
  localparam int SLOT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(W - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_LOADED, S_RUN} state_e;

  state_e                    state_q, state_d;
  logic [SLOT_W-1:0]         slot_q, slot_d;
  logic [CMD_WIDTH-1:0]      pack_q, pack_d;
  logic [CMD_WIDTH-1:0]      cmd_q, cmd_d;
  logic [CMD_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      we_q, we_d;
  logic [CMD_ADDR_WIDTH:0]   count_q, count_d;
  logic                      ovf_q, ovf_d;

  logic                      accept;
  logic                      fresh;
  logic                      complete;
  logic [CMD_ADDR_WIDTH:0]   count_eff;
  logic [CMD_WIDTH-1:0]      filled;

  // word_ready is driven from state only, so accept never loops back into it.
  assign accept   = bus.word_valid && bus.word_ready;
  // A word accepted in IDLE starts a new program: counters restart from zero.
  assign fresh    = (state_q == S_IDLE);
  assign complete = accept && (bus.word_last || (slot_q == LAST_SLOT));
  assign count_eff = fresh ? '0 : count_q;

  // slot_q and pack_q are kept at zero outside LOAD, so a fresh program
  // naturally starts at slot 0 and unfilled slots of a short command read 0.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_slot
      assign filled[gi*WORD_WIDTH +: WORD_WIDTH] =
        (slot_q == SLOT_W'(gi)) ? bus.word_in : pack_q[gi*WORD_WIDTH +: WORD_WIDTH];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A word arriving together with start takes priority: loading begins.
          if (accept) begin
            state_d = bus.word_last ? S_LOADED : S_LOAD;
          end else if (start) begin
            state_d = S_RUN;
          end
        end
        S_LOAD: begin
          if (accept && bus.word_last) begin
            state_d = S_LOADED;
          end
        end
        S_LOADED: begin
          if (start) begin
            state_d = S_RUN;
          end
        end
        S_RUN:   state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (Moore, from state only)
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.word_ready = 1'b0;
    proc_reset     = 1'b1;
    running        = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD: bus.word_ready = 1'b1;
      S_RUN: begin
        proc_reset = 1'b0;
        running    = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packing, write port and counters
  // ---------------------------------------------------------------------------
  always_comb begin
    slot_d  = slot_q;
    pack_d  = pack_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (stop) begin
      // Abandon any partial command; it is never written.
      slot_d = '0;
      pack_d = '0;
    end else if (accept) begin
      if (fresh) begin
        count_d = '0;
        ovf_d   = 1'b0;
      end
      if (complete) begin
        slot_d = '0;
        pack_d = '0;
        // count_eff's MSB set means every address has been written once:
        // the address must not wrap, so the write is dropped instead.
        if (count_eff[CMD_ADDR_WIDTH]) begin
          ovf_d = 1'b1;
        end else begin
          we_d    = 1'b1;
          cmd_d   = filled;
          addr_d  = count_eff[CMD_ADDR_WIDTH-1:0];
          count_d = count_eff + 1'b1;
        end
      end else begin
        slot_d = slot_q + 1'b1;
        pack_d = filled;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q  <= '0;
      pack_q  <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      pack_q  <= pack_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.cmd_write        = cmd_q;
  assign bus.cmd_write_addr   = addr_q;
  assign bus.cmd_write_enable = we_q;
  assign cmd_count            = count_q;
  assign overflow             = ovf_q;

`ifdef CMD_MEM_LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (stop) begin
      csum_d = '0;
    end else if (accept) begin
      // The first word of a new program restarts the running XOR.
      csum_d = fresh ? bus.word_in : (csum_q ^ bus.word_in);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_cmd_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_cmd_mem_loader
//   Self-checking bench for cmd_mem_loader (CMD_WIDTH=128, WORD_WIDTH=32,
//   CMD_ADDR_WIDTH=2 so the 4-entry memory overflows quickly). A transaction-
//   level model (program phase, chunk buffer, writes issued) predicts every
//   output each cycle; directed scenarios add literal expectations, followed
//   by a randomized stretch.
// -----------------------------------------------------------------------------
module tb_cmd_mem_loader;

  localparam int CW    = 128;
  localparam int WW    = 32;
  localparam int AW    = 2;
  localparam int WPC   = CW / WW;
  localparam int DEPTH = 1 << AW;

  localparam int P_IDLE   = 0;
  localparam int P_LOAD   = 1;
  localparam int P_LOADED = 2;
  localparam int P_RUN    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          proc_reset;
  logic          running;
  logic [AW:0]   cmd_count;
  logic          overflow;
`ifdef CMD_MEM_LOADER_CHECKSUM_EN
  logic [WW-1:0] checksum;
`endif

  cmd_mem_loader_if #(.CMD_WIDTH(CW), .CMD_ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

  cmd_mem_loader #(.CMD_WIDTH(CW), .CMD_ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .start      (start),
    .stop       (stop),
    .proc_reset (proc_reset),
    .running    (running),
    .cmd_count  (cmd_count),
    .overflow   (overflow)
`ifdef CMD_MEM_LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- counters ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int            m_phase = P_IDLE;
  logic [WW-1:0] chunk[$];          // words of the command being assembled
  int            m_chunks = 0;      // commands written this load
  bit            m_ovf = 1'b0;
  bit            m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [CW-1:0] m_data = '0;
  logic [WW-1:0] m_csum = '0;
  bit            chk_en = 1'b0;

  // observed writes
  logic [CW-1:0] cap[DEPTH];
  int            cap_n = 0;

  function automatic logic [CW-1:0] pack_chunk(input logic [WW-1:0] q[$]);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < q.size(); i++) r[i*WW +: WW] = q[i];
    return r;
  endfunction

  // Apply one cycle of inputs; the model advances at the same edge the DUT samples.
  task automatic step(input bit v, input logic [WW-1:0] w, input bit l,
                      input bit st, input bit sp, input bit rs);
    bit acc;
    bus.word_valid = v;
    bus.word_in    = w;
    bus.word_last  = l;
    start          = st;
    stop           = sp;
    reset          = rs;
    @(posedge clk);
    acc  = v && (m_phase == P_IDLE || m_phase == P_LOAD);
    m_we = 1'b0;
    if (rs) begin
      m_phase = P_IDLE; chunk.delete(); m_chunks = 0; m_ovf = 1'b0;
      m_addr = '0; m_data = '0; m_csum = '0;
    end else if (sp) begin
      m_phase = P_IDLE; chunk.delete(); m_csum = '0;
    end else if (acc) begin
      if (m_phase == P_IDLE) begin
        chunk.delete(); m_chunks = 0; m_ovf = 1'b0; m_csum = '0;
      end
      chunk.push_back(w);
      m_csum ^= w;
      if (chunk.size() == WPC || l) begin
        if (m_chunks < DEPTH) begin
          m_we = 1'b1; m_addr = AW'(m_chunks); m_data = pack_chunk(chunk); m_chunks++;
        end else begin
          m_ovf = 1'b1;
        end
        chunk.delete();
      end
      m_phase = l ? P_LOADED : P_LOAD;
    end else if (st && (m_phase == P_IDLE || m_phase == P_LOADED)) begin
      m_phase = P_RUN;
    end
    #1;
    bus.word_valid = 1'b0; bus.word_last = 1'b0;
    start = 1'b0; stop = 1'b0; reset = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0, 0);
  endtask

  task automatic load(input logic [WW-1:0] base, input int n);
    for (int i = 0; i < n; i++) step(1, base | WW'(i), (i == n - 1), 0, 0, 0);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("word_ready", CW'(bus.word_ready), CW'(m_phase == P_IDLE || m_phase == P_LOAD));
      chk("proc_reset", CW'(proc_reset), CW'(m_phase != P_RUN));
      chk("running",    CW'(running), CW'(m_phase == P_RUN));
      chk("cmd_we",     CW'(bus.cmd_write_enable), CW'(m_we));
      chk("cmd_addr",   CW'(bus.cmd_write_addr), CW'(m_addr));
      chk("cmd_data",   bus.cmd_write, m_data);
      chk("cmd_count",  CW'(cmd_count), CW'(m_chunks));
      chk("overflow",   CW'(overflow), CW'(m_ovf));
`ifdef CMD_MEM_LOADER_CHECKSUM_EN
      if (m_phase == P_LOADED || m_phase == P_RUN)
        chk("checksum", CW'(checksum), CW'(m_csum));
`endif
      if (bus.cmd_write_enable === 1'b1) begin
        cap[bus.cmd_write_addr] = bus.cmd_write;
        cap_n++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n0;
    bus.word_valid = 1'b0; bus.word_last = 1'b0; bus.word_in = '0;
    for (int i = 0; i < DEPTH; i++) cap[i] = '0;

    // reset
    step(0, '0, 0, 0, 0, 1);
    chk_en = 1'b1;
    chk("rst_proc_reset", CW'(proc_reset), CW'(1));
    chk("rst_word_ready", CW'(bus.word_ready), CW'(1));
    chk("rst_cmd_write",  bus.cmd_write, '0);
    idle(2);

    // 8 words, last on the 8th, then start
    load(32'hA000_0000, 8);
    idle(1);
    chk("lit_cmd0", cap[0], 128'hA0000003_A0000002_A0000001_A0000000);
    chk("lit_cmd1", cap[1], 128'hA0000007_A0000006_A0000005_A0000004);
    chk("lit_count2", CW'(cmd_count), CW'(2));
    chk("lit_pre_start_reset", CW'(proc_reset), CW'(1));
    step(0, '0, 0, 1, 0, 0);
    chk("lit_post_start_reset", CW'(proc_reset), CW'(0));

    // 5 words, short final command
    step(0, '0, 0, 0, 1, 0);
    load(32'hB000_0000, 5);
    idle(1);
    chk("lit_short_cmd", cap[1], 128'h00000000_00000000_00000000_B0000004);
    chk("lit_short_count", CW'(cmd_count), CW'(2));
    chk("lit_loaded_ready", CW'(bus.word_ready), CW'(0));

    // overflow: 20 words into a 4-deep memory
    step(0, '0, 0, 0, 1, 0);
    n0 = cap_n;
    load(32'hC000_0000, 20);
    idle(2);
    chk("lit_ovf_writes", CW'(cap_n - n0), CW'(4));
    chk("lit_ovf_flag", CW'(overflow), CW'(1));
    chk("lit_ovf_count", CW'(cmd_count), CW'(4));
    chk("lit_ovf_cmd3", cap[3], 128'hC000000F_C000000E_C000000D_C000000C);

    // stop after a partial command, then reload
    step(0, '0, 0, 0, 1, 0);
    n0 = cap_n;
    step(1, 32'hD000_0000, 0, 0, 0, 0);
    step(1, 32'hD000_0001, 0, 0, 0, 0);
    step(0, '0, 0, 0, 1, 0);
    load(32'hE000_0000, 4);
    idle(1);
    chk("lit_abort_writes", CW'(cap_n - n0), CW'(1));
    chk("lit_abort_cmd0", cap[0], 128'hE0000003_E0000002_E0000001_E0000000);
    chk("lit_abort_ovf", CW'(overflow), CW'(0));

    // RUN -> stop -> start, then start+stop together
    n0 = cap_n;
    step(0, '0, 0, 1, 0, 0);
    chk("lit_run1", CW'(proc_reset), CW'(0));
    step(0, '0, 0, 0, 1, 0);
    chk("lit_stopped", CW'(proc_reset), CW'(1));
    step(0, '0, 0, 1, 0, 0);
    chk("lit_rerun", CW'(proc_reset), CW'(0));
    step(0, '0, 0, 1, 1, 0);
    chk("lit_start_stop", CW'(proc_reset), CW'(1));
    idle(1);
    chk("lit_no_writes", CW'(cap_n - n0), CW'(0));

    // reset while the completing word is presented
    n0 = cap_n;
    load(32'hF000_0000, 3);  // last flag on the 3rd word ends this program
    step(0, '0, 0, 0, 1, 0);
    step(1, 32'h1, 0, 0, 0, 0);
    step(1, 32'h2, 0, 0, 0, 0);
    step(1, 32'h3, 0, 0, 0, 0);
    step(1, 32'h4, 0, 0, 0, 1);
    idle(1);
    chk("lit_rst_writes", CW'(cap_n - n0), CW'(1));
    chk("lit_rst_count", CW'(cmd_count), CW'(0));

`ifdef CMD_MEM_LOADER_CHECKSUM_EN
    step(1, 32'h1, 0, 0, 0, 0);
    step(1, 32'h2, 0, 0, 0, 0);
    step(1, 32'h4, 0, 0, 0, 0);
    step(1, 32'h8, 1, 0, 0, 0);
    chk("lit_checksum", CW'(checksum), CW'(32'hF));
    step(0, '0, 0, 0, 1, 0);
`endif

    // randomized stretch
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(9) < 7, $urandom, $urandom_range(11) == 0,
           $urandom_range(19) == 0, $urandom_range(39) == 0, $urandom_range(299) == 0);
    end
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cmd_mem_loader.md
# cmd_mem_loader

Sequencing controller for the distributed processor's command memory write port and processor reset. It accepts a 32-bit host word stream, packs words into CMD_WIDTH-bit commands, and writes them to consecutive command memory addresses. It holds the processor core in reset while a program is loaded, then releases it on a start request. It sits between the host/register interface and the cmd_write_addr/cmd_write/cmd_write_enable/reset inputs of the processor top level.

## Interface
- CMD_WIDTH, 128, command width; must be an integer multiple of WORD_WIDTH
- CMD_ADDR_WIDTH, 8, command memory address width
- WORD_WIDTH, 32, host word width
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- word_in  in  WORD_WIDTH  host data word
- word_valid  in  1  word_in valid
- word_last  in  1  qualifies the final word of a program
- word_ready  out  1  loader accepts a word this cycle
- start  in  1  single-cycle pulse; release the processor
- stop  in  1  single-cycle pulse; abort and return to IDLE
- cmd_write_addr  out  CMD_ADDR_WIDTH  command memory write address
- cmd_write  out  CMD_WIDTH  packed command
- cmd_write_enable  out  1  command memory write strobe
- proc_reset  out  1  processor reset, active-high
- running  out  1  high in RUN
- cmd_count  out  CMD_ADDR_WIDTH+1  number of commands written by the last load
- overflow  out  1  sticky; program exceeded memory depth

## Operation
- W = CMD_WIDTH/WORD_WIDTH words per command. Word k of a command (k = 0..W-1) lands in bits [WORD_WIDTH*(k+1)-1 : WORD_WIDTH*k].
- A word transfers when word_valid && word_ready.
- States:
  - IDLE: word_ready=1, proc_reset=1.
    - First accepted word → LOAD. It is packed as word 0; cmd_count and the address clear to 0 and overflow clears.
    - start → RUN (reruns the resident program).
  - LOAD: word_ready=1, proc_reset=1.
    - Each accepted word fills the next slot.
    - When slot W-1 fills, or word_last is accepted, the command is written and the address increments. Unfilled slots are written as 0.
    - Accepted word_last → LOADED.
  - LOADED: word_ready=0, proc_reset=1. start → RUN.
  - RUN: word_ready=0, proc_reset=0, running=1.
- stop in any state → IDLE next cycle, proc_reset=1. A partial command is discarded and never written.
- start is ignored in LOAD.
- If start and stop are high together, stop wins.
- Overflow: a command would be written with the address already past 2^CMD_ADDR_WIDTH-1 (i.e. after 2^CMD_ADDR_WIDTH writes).
  - The write is suppressed and overflow sets.
  - Further words are accepted and discarded until word_last, then → LOADED.
  - The address never wraps.
- cmd_count = number of commands written, saturating at 2^CMD_ADDR_WIDTH.

## Timing
- Reset values: state IDLE, proc_reset=1, word_ready=1, running=0, cmd_write_enable=0, cmd_write=0, cmd_write_addr=0, cmd_count=0, overflow=0.
- word_ready is combinational from state only, never from word_valid.
- Write latency: cmd_write_enable is a registered one-cycle pulse, asserted the cycle after the completing word is accepted.
  - cmd_write and cmd_write_addr are stable during that cycle.
- Back-to-back words sustain one word per cycle, i.e. one command every W cycles. No bubbles.
- proc_reset deasserts on the cycle after start is sampled.
- proc_reset reasserts on the cycle after stop or reset is sampled.
- LOAD→LOADED occurs the cycle after word_last is accepted. The final write pulse occurs in that same cycle.
- reset during LOAD: any pending write is dropped; all outputs return to reset values next cycle.

## Configuration
- CMD_MEM_LOADER_CHECKSUM_EN defined:
  - Adds output checksum[WORD_WIDTH-1:0], the XOR of every accepted word since the last IDLE→LOAD transition (discarded overflow words included).
  - Cleared by reset and stop.
  - Valid in LOADED and RUN.
- Undefined: the port and its logic are absent.

## Test plan
- Load 8 words (W=4) with word_last on word 8, then pulse start → two writes: addr 0 = {w3,w2,w1,w0}, addr 1 = {w7,w6,w5,w4}; cmd_count=2; proc_reset falls the cycle after start.
- Load 5 words, last on word 5 → addr 1 = {0,0,0,w4}; cmd_count=2; state LOADED, word_ready=0.
- CMD_ADDR_WIDTH=2, load 20 words → 4 writes (addr 0..3); overflow=1; cmd_count=4; no 5th write; LOADED reached after word 20.
- stop after 2 words of a command, then reload 4 words → no write from the aborted partial; new command written at addr 0.
- In RUN, pulse stop, then start from IDLE → proc_reset 0→1→0; memory contents untouched; start and stop in the same cycle keep proc_reset=1.
- With CMD_MEM_LOADER_CHECKSUM_EN, words 0x1,0x2,0x4,0x8 → checksum=0xF in LOADED.
